// File: rtl/electronic_lock_param_if.sv
// electronic_lock_param_if: keypad-side bundle for the parametrised code lock.
// master: keypad/debounce front end; slave: the lock. Signals:
//   key_valid/key_sym (symbol strobe), lock_req, prog_req (requests),
//   unlock, lockout, fail_cnt, sym_cnt (lock status, all registered).
interface electronic_lock_param_if #(
    parameter int SYM_W    = 1,
    parameter int CODE_LEN = 8,
    parameter int MAX_FAIL = 3
);
    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);

    logic          key_valid;
    logic [SYM_W-1:0] key_sym;
    logic          lock_req;
    logic          prog_req;
    logic          unlock;
    logic          lockout;
    logic [FW-1:0] fail_cnt;
    logic [CW-1:0] sym_cnt;

    modport master (
        output key_valid, key_sym, lock_req, prog_req,
        input  unlock, lockout, fail_cnt, sym_cnt
    );

    modport slave (
        input  key_valid, key_sym, lock_req, prog_req,
        output unlock, lockout, fail_cnt, sym_cnt
    );
endinterface

// File: rtl/electronic_lock_param.sv
// electronic_lock_param: keyed-symbol code lock with timed unlock,
// failure lockout and stale-entry timeout.
// Ports: clk (rising edge), rst (async, active low), bus (slave modport:
//   key_valid/key_sym in, lock_req/prog_req in, unlock/lockout/fail_cnt/
//   sym_cnt out). Optional macro ELOCK_PROG_EN adds code reprogramming.
module electronic_lock_param #(
    parameter int SYM_W       = 1,
    parameter int CODE_LEN    = 8,
    parameter logic [SYM_W*CODE_LEN-1:0] RESET_CODE = 8'b1011_0110,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 64,
    parameter int UNLOCK_CYC  = 16,
    parameter int ENTRY_TO    = 32
) (
    input  logic clk,
    input  logic rst,
    electronic_lock_param_if.slave bus
);
    localparam int CODE_W = SYM_W * CODE_LEN;
    localparam int CW     = $clog2(CODE_LEN + 1);
    localparam int FW     = $clog2(MAX_FAIL + 1);
    localparam int TMAX   = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int IW     = $clog2(ENTRY_TO + 1);

    localparam logic [CW-1:0] LAST_SYM = CW'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_LIM = FW'(MAX_FAIL);
    localparam logic [TW-1:0] UNL_LAST = TW'(UNLOCK_CYC - 1);
    localparam logic [TW-1:0] LCK_LAST = TW'(LOCKOUT_CYC - 1);
    localparam logic [IW-1:0] IDLE_LIM = IW'(ENTRY_TO);

    typedef enum logic [1:0] {
        S_LOCKED,
        S_OPEN,
        S_LOCKOUT
`ifdef ELOCK_PROG_EN
        , S_PROG
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] sym_q, sym_d;
    logic          mis_q, mis_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          unlock_q, lockout_q;
    logic [CODE_W-1:0] code;

`ifdef ELOCK_PROG_EN
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] shadow_q, shadow_d;
    assign code = code_q;
`else
    logic unused_prog;
    assign unused_prog = bus.prog_req;
    assign code = RESET_CODE;
`endif

    // Symbol table padded to a power of two so sym_cnt indexes it directly.
    logic [SYM_W-1:0] code_sym [2**CW];
    for (genvar k = 0; k < 2**CW; k++) begin : g_sym
        if (k < CODE_LEN) begin : g_v
            assign code_sym[k] = code[k*SYM_W +: SYM_W];
        end else begin : g_z
            assign code_sym[k] = '0;
        end
    end

    // A partial attempt idle for ENTRY_TO cycles is stale; a key arriving
    // now starts a fresh attempt as symbol 0.
    logic          stale;
    logic [CW-1:0] cur_sym;
    logic          cur_mis;
    logic          miss;

    assign stale   = (sym_q != '0) && (idle_q == IDLE_LIM);
    assign cur_sym = stale ? '0 : sym_q;
    assign cur_mis = stale ? 1'b0 : mis_q;
    assign miss    = cur_mis | (bus.key_sym != code_sym[cur_sym]);

    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        mis_d   = mis_q;
        fail_d  = fail_q;
        tmr_d   = tmr_q;
        idle_d  = idle_q;
`ifdef ELOCK_PROG_EN
        shadow_d = shadow_q;
        code_d   = code_q;
`endif
        unique case (state_q)
            S_LOCKED: begin
                if (bus.key_valid) begin
                    idle_d = '0;
                    if (cur_sym == LAST_SYM) begin
                        sym_d = '0;
                        mis_d = 1'b0;
                        if (!miss) begin
                            state_d = S_OPEN;
                            fail_d  = '0;
                            tmr_d   = '0;
                        end else if (fail_q + FW'(1) == FAIL_LIM) begin
                            state_d = S_LOCKOUT;
                            fail_d  = FAIL_LIM;
                            tmr_d   = '0;
                        end else begin
                            fail_d = fail_q + FW'(1);
                        end
                    end else begin
                        sym_d = cur_sym + CW'(1);
                        mis_d = miss;
                    end
                end else if (stale) begin
                    sym_d  = '0;
                    mis_d  = 1'b0;
                    idle_d = '0;
                end else if (sym_q != '0) begin
                    idle_d = idle_q + IW'(1);
                end
            end
            S_OPEN: begin
                if (bus.lock_req) begin
                    state_d = S_LOCKED;
`ifdef ELOCK_PROG_EN
                end else if (bus.prog_req) begin
                    state_d = S_PROG;
                    sym_d   = '0;
                    idle_d  = '0;
`endif
                end else if (tmr_q == UNL_LAST) begin
                    state_d = S_LOCKED;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_LOCKOUT: begin
                if (tmr_q == LCK_LAST) begin
                    state_d = S_LOCKED;
                    fail_d  = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
`ifdef ELOCK_PROG_EN
            S_PROG: begin
                if (bus.lock_req || idle_q == IDLE_LIM) begin
                    state_d = S_LOCKED;
                    sym_d   = '0;
                    idle_d  = '0;
                end else if (bus.key_valid) begin
                    idle_d = '0;
                    // Shift in from the top: after CODE_LEN keys symbol 0
                    // sits in the lowest slot.
                    shadow_d = {bus.key_sym, shadow_q[CODE_W-1:SYM_W]};
                    if (sym_q == LAST_SYM) begin
                        code_d  = shadow_d;
                        fail_d  = '0;
                        state_d = S_LOCKED;
                        sym_d   = '0;
                    end else begin
                        sym_d = sym_q + CW'(1);
                    end
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
`endif
            default: state_d = S_LOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_LOCKED;
            sym_q     <= '0;
            mis_q     <= 1'b0;
            fail_q    <= '0;
            tmr_q     <= '0;
            idle_q    <= '0;
            unlock_q  <= 1'b0;
            lockout_q <= 1'b0;
`ifdef ELOCK_PROG_EN
            code_q    <= RESET_CODE;
            shadow_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sym_q     <= sym_d;
            mis_q     <= mis_d;
            fail_q    <= fail_d;
            tmr_q     <= tmr_d;
            idle_q    <= idle_d;
            unlock_q  <= (state_d == S_OPEN);
            lockout_q <= (state_d == S_LOCKOUT);
`ifdef ELOCK_PROG_EN
            code_q    <= code_d;
            shadow_q  <= shadow_d;
`endif
        end
    end

    assign bus.unlock   = unlock_q;
    assign bus.lockout  = lockout_q;
    assign bus.fail_cnt = fail_q;
    assign bus.sym_cnt  = sym_q;
endmodule

// File: tb/tb_electronic_lock_param.sv
// tb_electronic_lock_param: directed + random stimulus for the code lock,
// checked each cycle against a queue-based behavioural model.
module tb_electronic_lock_param;
    localparam int SYM_W    = 1;
    localparam int CODE_LEN = 8;
    localparam logic [7:0] CODE = 8'b1011_0110;
    localparam int MAX_FAIL = 3;
    localparam int LOCKOUT_CYC = 64;
    localparam int UNLOCK_CYC  = 16;
    localparam int ENTRY_TO    = 32;
`ifdef ELOCK_PROG_EN
    localparam bit PROG_EN = 1'b1;
`else
    localparam bit PROG_EN = 1'b0;
`endif

    localparam int M_LOCKED  = 0;
    localparam int M_OPEN    = 1;
    localparam int M_LOCKOUT = 2;
    localparam int M_PROG    = 3;

    logic clk;
    logic rst;
    bit   chk_en;
    int   n_tests;
    int   n_fail;

    electronic_lock_param_if #(
        .SYM_W(SYM_W), .CODE_LEN(CODE_LEN), .MAX_FAIL(MAX_FAIL)
    ) bus ();

    electronic_lock_param #(
        .SYM_W(SYM_W), .CODE_LEN(CODE_LEN), .RESET_CODE(CODE),
        .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYC(LOCKOUT_CYC),
        .UNLOCK_CYC(UNLOCK_CYC), .ENTRY_TO(ENTRY_TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: attempt kept as a symbol queue, timers count down.
    int         m_mode;
    bit         m_att[$];
    int         m_idle;
    int         m_left;
    int         m_fail;
    logic [7:0] m_code;

    task automatic m_reset();
        m_mode = M_LOCKED;
        m_att.delete();
        m_idle = 0;
        m_left = 0;
        m_fail = 0;
        m_code = CODE;
    endtask

    task automatic m_step(input logic kv, input logic ks,
                          input logic lr, input logic pr);
        bit ok;
        case (m_mode)
            M_LOCKED: begin
                if (m_att.size() > 0 && m_idle == ENTRY_TO) begin
                    m_att.delete();
                    m_idle = 0;
                end
                if (kv) begin
                    m_att.push_back(ks);
                    m_idle = 0;
                    if (m_att.size() == CODE_LEN) begin
                        ok = 1'b1;
                        for (int i = 0; i < CODE_LEN; i++)
                            if (m_att[i] != m_code[i]) ok = 1'b0;
                        m_att.delete();
                        if (ok) begin
                            m_mode = M_OPEN;
                            m_left = UNLOCK_CYC;
                            m_fail = 0;
                        end else begin
                            m_fail++;
                            if (m_fail == MAX_FAIL) begin
                                m_mode = M_LOCKOUT;
                                m_left = LOCKOUT_CYC;
                            end
                        end
                    end
                end else if (m_att.size() > 0) begin
                    m_idle++;
                end
            end
            M_OPEN: begin
                if (lr) m_mode = M_LOCKED;
                else if (PROG_EN && pr) begin
                    m_mode = M_PROG;
                    m_att.delete();
                    m_idle = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_LOCKED;
                end
            end
            M_LOCKOUT: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = M_LOCKED;
                    m_fail = 0;
                end
            end
            default: begin
                if (lr || m_idle == ENTRY_TO) begin
                    m_mode = M_LOCKED;
                    m_att.delete();
                    m_idle = 0;
                end else if (kv) begin
                    m_att.push_back(ks);
                    m_idle = 0;
                    if (m_att.size() == CODE_LEN) begin
                        for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_att[i];
                        m_att.delete();
                        m_fail = 0;
                        m_mode = M_LOCKED;
                    end
                end else begin
                    m_idle++;
                end
            end
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) m_reset();
        else m_step(bus.key_valid, bus.key_sym, bus.lock_req, bus.prog_req);
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && chk_en) begin
            check("cyc_unlock", bus.unlock, m_mode == M_OPEN);
            check("cyc_lockout", bus.lockout, m_mode == M_LOCKOUT);
            check("cyc_fail_cnt", bus.fail_cnt, m_fail);
            check("cyc_sym_cnt", bus.sym_cnt,
                  (m_mode == M_LOCKED || m_mode == M_PROG) ? m_att.size() : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic s);
        bus.key_valid = 1'b1;
        bus.key_sym   = s;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic enter_code(input logic [7:0] c);
        for (int i = 0; i < CODE_LEN; i++) begin
            key(c[i]);
            if (i < CODE_LEN - 1) tick();
        end
    endtask

    task automatic relock();
        bus.lock_req = 1'b1;
        tick();
        bus.lock_req = 1'b0;
        check("relock_unlock", bus.unlock, 0);
        tick();
    endtask

    task automatic three_wrong();
        for (int a = 0; a < MAX_FAIL; a++) begin
            enter_code(8'hFF);
            tick();
        end
    endtask

    initial begin
        chk_en  = 1'b0;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_sym   = 1'b0;
        bus.lock_req  = 1'b0;
        bus.prog_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_unlock", bus.unlock, 0);
        check("rst_lockout", bus.lockout, 0);
        check("rst_fail_cnt", bus.fail_cnt, 0);
        check("rst_sym_cnt", bus.sym_cnt, 0);
        rst = 1'b1;
        chk_en = 1'b1;
        tick();

        // Correct code: unlock one cycle after last strobe, held 16 cycles.
        enter_code(CODE);
        check("open_unlock", bus.unlock, 1);
        check("open_sym_cnt", bus.sym_cnt, 0);
        repeat (UNLOCK_CYC - 1) tick();
        check("hold_last_unlock", bus.unlock, 1);
        tick();
        check("hold_end_unlock", bus.unlock, 0);
        tick();

        // Three wrong attempts -> lockout; correct code ignored meanwhile.
        enter_code(8'hFF);
        check("wrong1_fail", bus.fail_cnt, 1);
        tick();
        enter_code(8'hFF);
        check("wrong2_fail", bus.fail_cnt, 2);
        tick();
        enter_code(8'hFF);
        check("wrong3_lockout", bus.lockout, 1);
        tick();
        enter_code(CODE);
        check("lockout_no_unlock", bus.unlock, 0);
        check("lockout_held", bus.lockout, 1);
        for (int i = 0; i < 100 && bus.lockout; i++) tick();
        check("lockout_ends", bus.lockout, 0);
        check("lockout_fail_clr", bus.fail_cnt, 0);
        tick();
        enter_code(CODE);
        check("post_lockout_unlock", bus.unlock, 1);
        relock();

        // Stale partial entry discarded, not counted as failure.
        for (int i = 0; i < 4; i++) begin
            key(CODE[i]);
            tick();
        end
        check("partial_sym_cnt", bus.sym_cnt, 4);
        repeat (40) tick();
        check("timeout_sym_cnt", bus.sym_cnt, 0);
        check("timeout_fail", bus.fail_cnt, 0);
        enter_code(CODE);
        check("timeout_then_unlock", bus.unlock, 1);
        relock();

        // Key in the expiry cycle becomes symbol 0 of a new attempt.
        for (int i = 0; i < 3; i++) begin
            key(CODE[i]);
            if (i < 2) tick();
        end
        repeat (ENTRY_TO) tick();
        check("pre_expiry_sym_cnt", bus.sym_cnt, 3);
        key(CODE[0]);
        check("expiry_key_sym_cnt", bus.sym_cnt, 1);
        for (int i = 1; i < CODE_LEN; i++) begin
            tick();
            key(CODE[i]);
        end
        check("expiry_restart_unlock", bus.unlock, 1);
        relock();

        // lock_req and prog_req together on OPEN cycle 3: lock wins.
        enter_code(CODE);
        tick();
        tick();
        bus.lock_req = 1'b1;
        bus.prog_req = 1'b1;
        tick();
        bus.lock_req = 1'b0;
        bus.prog_req = 1'b0;
        check("lock_wins_unlock", bus.unlock, 0);
        tick();
        enter_code(CODE);
        check("lock_wins_relocked", bus.unlock, 1);
        relock();

        // Asynchronous reset mid-lockout and mid-unlock.
        three_wrong();
        repeat (10) tick();
        #3;
        rst = 1'b0;
        #1;
        check("arst_lockout", bus.lockout, 0);
        check("arst_lockout_fail", bus.fail_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        enter_code(CODE);
        repeat (4) tick();
        #3;
        rst = 1'b0;
        #1;
        check("arst_unlock", bus.unlock, 0);
        check("arst_sym_cnt", bus.sym_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

`ifdef ELOCK_PROG_EN
        // Reprogram to 11110000 (LSB first), then abort a PROG.
        enter_code(CODE);
        tick();
        bus.prog_req = 1'b1;
        tick();
        bus.prog_req = 1'b0;
        check("prog_unlock_drop", bus.unlock, 0);
        tick();
        enter_code(8'b1111_0000);
        check("prog_commit_sym", bus.sym_cnt, 0);
        tick();
        enter_code(CODE);
        check("old_code_rejected", bus.fail_cnt, 1);
        check("old_code_no_unlock", bus.unlock, 0);
        tick();
        enter_code(8'b1111_0000);
        check("new_code_unlock", bus.unlock, 1);
        check("new_code_fail", bus.fail_cnt, 0);
        tick();
        bus.prog_req = 1'b1;
        tick();
        bus.prog_req = 1'b0;
        key(1'b1);
        tick();
        key(1'b0);
        check("prog_sym_cnt", bus.sym_cnt, 2);
        bus.lock_req = 1'b1;
        tick();
        bus.lock_req = 1'b0;
        check("prog_abort_sym", bus.sym_cnt, 0);
        tick();
        enter_code(8'b1111_0000);
        check("abort_code_kept", bus.unlock, 1);
        relock();
`endif

        // Random traffic, biased toward correct symbols so all states occur.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                bus.key_valid = 1'b0;
                bus.lock_req  = 1'b0;
                bus.prog_req  = 1'b0;
                repeat (34) tick();
            end
            bus.key_valid = ($urandom_range(0, 99) < 35);
            if ($urandom_range(0, 9) < 7)
                bus.key_sym = m_code[m_att.size()];
            else
                bus.key_sym = 1'($urandom_range(0, 1));
            bus.lock_req = ($urandom_range(0, 39) == 0);
            bus.prog_req = ($urandom_range(0, 29) == 0);
            tick();
        end
        bus.key_valid = 1'b0;
        bus.lock_req  = 1'b0;
        bus.prog_req  = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
